// File: rtl/spn_stream_serializer.sv
// -----------------------------------------------------------------------------
// spn_stream_serializer
//
// Converts PARA-lane parallel vectors into a serial stream of DATA_WIDTH words.
// Vectors are held in a two-entry ping-pong buffer so a new vector can be
// accepted while the previous one is still being shifted out, which gives
// bubble-free streaming when a vector arrives every PARA cycles.
//
// Parameters
//   DATA_WIDTH : width of one lane word
//   PARA       : lanes per vector (power of two, >= 2)
//   LANE_ORDER : 0 = lane 0 first, 1 = lane PARA-1 first
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   input_stream : parallel vector (PARA words)
//   valid_in     : input_stream holds a vector this cycle
//   in_ready     : buffer has a free entry (registered state only)
//   out_data     : current serial word
//   out_valid    : out_data is valid
//   out_ready    : downstream accepts out_data this cycle
//   out_last     : out_data is the final word of its vector
//   drop_err     : sticky flag, a vector arrived while in_ready was low
// -----------------------------------------------------------------------------
module spn_stream_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int PARA       = 16,
    parameter int LANE_ORDER = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_stream [PARA],
    input  logic                  valid_in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  drop_err
);

    localparam int LW = $clog2(PARA);
    localparam logic [LW-1:0] LAST_LANE = LW'(PARA - 1);

    // Ping-pong storage: two entries of PARA words each
    logic [DATA_WIDTH-1:0] r_mem [2][PARA];

    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic [LW-1:0] r_lane_idx;
    logic          r_drop_err;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_beat;
    logic          w_last_lane;
    logic [LW-1:0] w_lane_sel;

    // Handshake decode; in_ready depends on registered occupancy only, so
    // a final-beat pop from a full buffer does not open in_ready that cycle
    assign w_in_ready  = (r_count != 2'd2);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = valid_in && w_in_ready;
    assign w_beat      = w_out_valid && out_ready;
    assign w_last_lane = (r_lane_idx == LAST_LANE);

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_last  = w_out_valid && w_last_lane;
    assign drop_err  = r_drop_err;

    // Map the lane counter to a physical lane according to LANE_ORDER
    always_comb begin
        w_lane_sel = r_lane_idx;
        if (LANE_ORDER == 1) begin
            w_lane_sel = LAST_LANE - r_lane_idx;
        end else begin
            w_lane_sel = r_lane_idx;
        end
    end

    // Serial output word straight from storage; holds while lane/rd_ptr hold
    always_comb begin
        out_data = r_mem[r_rd_ptr][w_lane_sel];
    end

    // Vector storage write; contents are not cleared by reset because the
    // pointers and occupancy already mark every entry as empty
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= input_stream;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Pointer, occupancy, lane counter and error-flag state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_lane_idx <= '0;
            r_drop_err <= 1'b0;
        end else begin
            // A pop only happens on the final beat of the head vector
            case ({w_push, w_beat && w_last_lane})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end

            if (w_beat && w_last_lane) begin
                r_lane_idx <= '0;
                r_rd_ptr   <= ~r_rd_ptr;
            end else if (w_beat) begin
                r_lane_idx <= r_lane_idx + LW'(1);
                r_rd_ptr   <= r_rd_ptr;
            end else begin
                r_lane_idx <= r_lane_idx;
                r_rd_ptr   <= r_rd_ptr;
            end

            // Discarded vector: flag sticks until the next reset
            if (valid_in && !w_in_ready) begin
                r_drop_err <= 1'b1;
            end else begin
                r_drop_err <= r_drop_err;
            end
        end
    end

endmodule
